// File: rtl/mem_master_pkg.sv
// Shared encodings for the data-memory load/store engine.
package mem_master_pkg;

   localparam int WADDR_W = 18;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   // A reserved size is answered straight from IDLE, so no separate error state is needed.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ACC1 = 3'd1,
      ST_ACC2 = 3'd2,
      ST_WAIT = 3'd3
   } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Lane enables, shifted store data and extended load data for a size/offset pair.
module mem_lane_align
   import mem_master_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_word_lo,
   input  logic [31:0] i_word_hi,
   input  logic        i_unsigned,
   output logic        o_cross,
   output logic [3:0]  o_be1,
   output logic [3:0]  o_be2,
   output logic [31:0] o_wdata1,
   output logic [31:0] o_wdata2,
   output logic [31:0] o_rdata
);

   logic [3:0]  w_base;
   logic [7:0]  w_lanes;
   logic [4:0]  w_shamt;
   logic [63:0] w_wshift;
   logic [31:0] w_rsel;

   always_comb begin
      w_base = 4'b0000;
      case (i_size)
         SZ_BYTE: w_base = 4'b0001;
         SZ_HALF: w_base = 4'b0011;
         SZ_WORD: w_base = 4'b1111;
         default: w_base = 4'b0000;
      endcase
   end

   // Lanes spilling into the upper nibble belong to the next word.
   assign w_lanes  = {4'b0000, w_base} << i_offset;
   assign o_be1    = w_lanes[3:0];
   assign o_be2    = w_lanes[7:4];
   assign o_cross  = (w_lanes[7:4] != 4'b0000);

   assign w_shamt  = {i_offset, 3'b000};
   assign w_wshift = {32'h0000_0000, i_wdata} << w_shamt;
   assign o_wdata1 = w_wshift[31:0];
   assign o_wdata2 = w_wshift[63:32];

   assign w_rsel   = 32'({i_word_hi, i_word_lo} >> w_shamt);

   always_comb begin
      o_rdata = 32'h0000_0000;
      case (i_size)
         SZ_BYTE: o_rdata = i_unsigned ? {24'h000000, w_rsel[7:0]}
                                       : {{24{w_rsel[7]}}, w_rsel[7:0]};
         SZ_HALF: o_rdata = i_unsigned ? {16'h0000, w_rsel[15:0]}
                                       : {{16{w_rsel[15]}}, w_rsel[15:0]};
         SZ_WORD: o_rdata = w_rsel;
         default: o_rdata = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/data_mem_master.sv
// Load/store engine: one request at a time, split into one or two word accesses.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle pulse.
module data_mem_master
   import mem_master_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_write,
   output logic [3:0]  byte_en,
   output logic [17:0] write_addr,
   output logic [17:0] read_addr,
   output logic [31:0] write_data,
   input  logic [31:0] read_data,
   output logic [2:0]  dbg_state
);

   state_t               r_state;
   logic                 r_req_ready, r_rsp_valid, r_rsp_err, r_mem_write;
   logic [3:0]           r_byte_en, r_be2;
   logic [WADDR_W-1:0]   r_write_addr, r_read_addr, r_w2;
   logic [31:0]          r_write_data, r_rsp_rdata, r_wd2, r_word0;
   logic                 r_we, r_uns, r_cross;
   logic [1:0]           r_size, r_off;

   logic                 w_idle, w_cross, w_unused;
   logic [1:0]           w_size, w_off;
   logic [3:0]           w_be1, w_be2;
   logic [31:0]          w_wd1, w_wd2, w_rdata, w_word_lo, w_word_hi;
   logic [WADDR_W-1:0]   w_waddr;

   // The aligner sees the live request in IDLE and the captured one afterwards.
   assign w_idle    = (r_state == ST_IDLE);
   assign w_size    = w_idle ? req_size     : r_size;
   assign w_off     = w_idle ? req_addr[1:0] : r_off;
   assign w_waddr   = req_addr[19:2];
   assign w_word_lo = r_cross ? r_word0   : read_data;
   assign w_word_hi = r_cross ? read_data : 32'h0000_0000;
   assign w_unused  = ^req_addr[31:20];

   mem_lane_align u_align (
      .i_size     (w_size),
      .i_offset   (w_off),
      .i_wdata    (req_wdata),
      .i_word_lo  (w_word_lo),
      .i_word_hi  (w_word_hi),
      .i_unsigned (r_uns),
      .o_cross    (w_cross),
      .o_be1      (w_be1),
      .o_be2      (w_be2),
      .o_wdata1   (w_wd1),
      .o_wdata2   (w_wd2),
      .o_rdata    (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_req_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_rsp_rdata  <= 32'h0000_0000;
         r_mem_write  <= 1'b0;
         r_byte_en    <= 4'b0000;
         r_write_addr <= '0;
         r_read_addr  <= '0;
         r_write_data <= 32'h0000_0000;
         r_we         <= 1'b0;
         r_uns        <= 1'b0;
         r_cross      <= 1'b0;
         r_size       <= SZ_BYTE;
         r_off        <= 2'b00;
         r_w2         <= '0;
         r_be2        <= 4'b0000;
         r_wd2        <= 32'h0000_0000;
         r_word0      <= 32'h0000_0000;
      end else begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_mem_write <= 1'b0;
         r_byte_en   <= 4'b0000;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_uns   <= req_unsigned;
                  r_size  <= req_size;
                  r_off   <= req_addr[1:0];
                  r_cross <= w_cross;
                  r_w2    <= w_waddr + 18'd1;
                  r_be2   <= w_be2;
                  r_wd2   <= w_wd2;
                  if (req_size == SZ_RSVD) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= 32'h0000_0000;
                  end else begin
                     r_state     <= ST_ACC1;
                     r_req_ready <= 1'b0;
                     if (req_we) begin
                        r_mem_write  <= 1'b1;
                        r_byte_en    <= w_be1;
                        r_write_addr <= w_waddr;
                        r_write_data <= w_wd1;
                     end else begin
                        r_read_addr  <= w_waddr;
                     end
                  end
               end
            end
            ST_ACC1: begin
               if (r_cross) begin
                  r_state <= ST_ACC2;
                  if (r_we) begin
                     r_mem_write  <= 1'b1;
                     r_byte_en    <= r_be2;
                     r_write_addr <= r_w2;
                     r_write_data <= r_wd2;
                  end else begin
                     r_read_addr  <= r_w2;
                  end
               end else if (r_we) begin
                  r_state     <= ST_IDLE;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= 32'h0000_0000;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_ACC2: begin
               r_word0 <= read_data;
               if (r_we) begin
                  r_state     <= ST_IDLE;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= 32'h0000_0000;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= w_rdata;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_err    = r_rsp_err;
   assign rsp_rdata  = r_rsp_rdata;
   assign mem_write  = r_mem_write;
   assign byte_en    = r_byte_en;
   assign write_addr = r_write_addr;
   assign read_addr  = r_read_addr;
   assign write_data = r_write_data;
   assign dbg_state  = r_state;

endmodule
